// File: rtl/bus_dma_master_if.sv
// -----------------------------------------------------------------------------
// bus_dma_master_if
//   Master-side view of one port of the two-master shared bus.
//
//   m_req   master -> arbiter  bus request
//   m_grant arbiter -> master  bus grant
//   m_wr    master -> bus      1 = write cycle, 0 = read cycle
//   m_addr  master -> bus      word address (AW bits)
//   m_dout  master -> bus      write data (DW bits)
//   m_din   bus -> master      read data, valid in the same cycle as m_addr
// -----------------------------------------------------------------------------
interface bus_dma_master_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          m_req;
    logic          m_grant;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;

    modport master (
        output m_req,
        output m_wr,
        output m_addr,
        output m_dout,
        input  m_grant,
        input  m_din
    );

    modport slave (
        input  m_req,
        input  m_wr,
        input  m_addr,
        input  m_dout,
        output m_grant,
        output m_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// -----------------------------------------------------------------------------
// bus_dma_master
//   Single-channel copy engine. On an accepted start it requests the shared
//   bus, and once granted copies `length` words from src_addr to dst_addr as
//   alternating single-word read and write cycles, then pulses done.
//
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     one-cycle command strobe, only sampled in IDLE
//   src_addr  first source word address (latched on accepted start)
//   dst_addr  first destination word address (latched on accepted start)
//   length    number of words to copy (latched on accepted start)
//   bus       master modport: m_req/m_grant/m_wr/m_addr/m_dout/m_din
//   busy      high from accepted start until DONE exits
//   done      one-cycle completion pulse
// -----------------------------------------------------------------------------
module bus_dma_master #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [AW-1:0]       src_addr,
    input  logic [AW-1:0]       dst_addr,
    input  logic [LW-1:0]       length,
    bus_dma_master_if.master    bus,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [DW-1:0] data_q;

    logic [LW-1:0] idx_next;
    logic [AW-1:0] idx_addr;

    assign idx_next = idx_q + LW'(1);
    // Word offset resized to the address width; sums below wrap mod 2^AW.
    assign idx_addr = AW'(idx_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= length;
                        idx_q   <= '0;
                        // A zero-length copy completes without touching the bus.
                        state_q <= (length == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.m_grant) begin
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    if (bus.m_grant) begin
                        data_q  <= bus.m_din;
                        state_q <= S_WR;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WR: begin
                    if (bus.m_grant) begin
                        idx_q   <= idx_next;
                        state_q <= (idx_next == len_q) ? S_DONE : S_RD;
                    end else begin
                        // Grant lost: the same word is retried from its read.
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore output decode: state and registered fields only.
    always_comb begin
        bus.m_req  = 1'b0;
        bus.m_wr   = 1'b0;
        bus.m_addr = '0;
        bus.m_dout = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_REQ: begin
                bus.m_req = 1'b1;
                busy      = 1'b1;
            end
            S_RD: begin
                bus.m_req  = 1'b1;
                bus.m_addr = src_q + idx_addr;
                busy       = 1'b1;
            end
            S_WR: begin
                bus.m_req  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = dst_q + idx_addr;
                bus.m_dout = data_q;
                busy       = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// -----------------------------------------------------------------------------
// tb_bus_dma_master
//   Directed bench for bus_dma_master. A small bus model supplies read data
//   from a source table and counts write cycles; the arbiter model either
//   forces grant, or returns it one cycle after the request.
// -----------------------------------------------------------------------------
module tb_bus_dma_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;

    // 0 = grant low, 1 = grant high, 2 = grant one cycle after request
    logic [1:0]    gmode;
    logic          req_d;

    logic [DW-1:0] rom  [256];
    logic [DW-1:0] wmem [256];
    int            wr_cnt   = 0;
    int            done_cnt = 0;

    int checks = 0;
    int errors = 0;

    bus_dma_master_if #(.AW(AW), .DW(DW)) bus ();

    bus_dma_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) req_d <= 1'b0;
        else          req_d <= bus.m_req;
    end

    assign bus.m_grant = (gmode == 2'd2) ? req_d : gmode[0];
    assign bus.m_din   = rom[bus.m_addr];

    always @(posedge clk) begin
        if (bus.m_req && bus.m_grant && bus.m_wr) begin
            wmem[bus.m_addr] <= bus.m_dout;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic req, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] dout,
                       input logic bsy, input logic dn);
        logic [43:0] obs;
        logic [43:0] exp;
        obs = {bus.m_req, bus.m_wr, bus.m_addr, bus.m_dout, busy, done};
        exp = {req, wr, addr, dout, bsy, dn};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed req/wr/addr/dout/busy/done=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drop start, check the bus outputs.
    task automatic step(input string tag, input logic req, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] dout,
                        input logic bsy, input logic dn);
        @(negedge clk);
        start = 1'b0;
        chk(tag, req, wr, addr, dout, bsy, dn);
    endtask

    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        gmode    = 2'd1;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        rom[8'h00] = 32'hA;
        rom[8'h01] = 32'hB;
        rom[8'h02] = 32'hC;
        rom[8'h20] = 32'h11;
        rom[8'h21] = 32'h22;
        rom[8'h22] = 32'h33;
        rom[8'h40] = 32'h1234;
        rom[8'h41] = 32'h5678;
        rom[8'hFE] = 32'hAA;
        rom[8'hFF] = 32'hBB;

        // Reset, then idle with grant held high
        #1 chk("reset", 0, 0, 8'h00, 32'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 8'h00, 32'h0, 0, 0);

        // Three-word copy, grant one cycle after request
        gmode = 2'd2;
        issue(8'h00, 8'h10, 8'd3);
        step("t3 req0", 1, 0, 8'h00, 32'h0, 1, 0);
        step("t3 req1", 1, 0, 8'h00, 32'h0, 1, 0);
        step("t3 rd0",  1, 0, 8'h00, 32'h0, 1, 0);
        step("t3 wr0",  1, 1, 8'h10, 32'hA, 1, 0);
        step("t3 rd1",  1, 0, 8'h01, 32'h0, 1, 0);
        step("t3 wr1",  1, 1, 8'h11, 32'hB, 1, 0);
        step("t3 rd2",  1, 0, 8'h02, 32'h0, 1, 0);
        step("t3 wr2",  1, 1, 8'h12, 32'hC, 1, 0);
        step("t3 done", 0, 0, 8'h00, 32'h0, 1, 1);
        step("t3 idle", 0, 0, 8'h00, 32'h0, 0, 0);
        chk_val("t3 mem10", wmem[8'h10], 32'hA);
        chk_val("t3 mem11", wmem[8'h11], 32'hB);
        chk_val("t3 mem12", wmem[8'h12], 32'hC);

        // Zero-length copy never requests the bus
        issue(8'h33, 8'h44, 8'd0);
        step("len0 done", 0, 0, 8'h00, 32'h0, 1, 1);
        step("len0 idle", 0, 0, 8'h00, 32'h0, 0, 0);
        step("len0 idle2", 0, 0, 8'h00, 32'h0, 0, 0);

        // Grant withheld for five cycles
        gmode = 2'd0;
        issue(8'h40, 8'h50, 8'd2);
        for (int i = 0; i < 5; i++) step("dly req", 1, 0, 8'h00, 32'h0, 1, 0);
        gmode = 2'd2;
        step("dly rd0",  1, 0, 8'h40, 32'h0, 1, 0);
        step("dly wr0",  1, 1, 8'h50, 32'h1234, 1, 0);
        step("dly rd1",  1, 0, 8'h41, 32'h0, 1, 0);
        step("dly wr1",  1, 1, 8'h51, 32'h5678, 1, 0);
        step("dly done", 0, 0, 8'h00, 32'h0, 1, 1);
        step("dly idle", 0, 0, 8'h00, 32'h0, 0, 0);
        chk_val("dly mem50", wmem[8'h50], 32'h1234);
        chk_val("dly mem51", wmem[8'h51], 32'h5678);

        // Grant dropped during the write of word 1
        issue(8'h20, 8'h30, 8'd3);
        step("drop req0", 1, 0, 8'h00, 32'h0, 1, 0);
        step("drop req1", 1, 0, 8'h00, 32'h0, 1, 0);
        step("drop rd0",  1, 0, 8'h20, 32'h0, 1, 0);
        step("drop wr0",  1, 1, 8'h30, 32'h11, 1, 0);
        step("drop rd1",  1, 0, 8'h21, 32'h0, 1, 0);
        step("drop wr1",  1, 1, 8'h31, 32'h22, 1, 0);
        gmode = 2'd0;
        step("drop rereq", 1, 0, 8'h00, 32'h0, 1, 0);
        gmode = 2'd2;
        step("drop rd1b", 1, 0, 8'h21, 32'h0, 1, 0);
        step("drop wr1b", 1, 1, 8'h31, 32'h22, 1, 0);
        step("drop rd2",  1, 0, 8'h22, 32'h0, 1, 0);
        step("drop wr2",  1, 1, 8'h32, 32'h33, 1, 0);
        step("drop done", 0, 0, 8'h00, 32'h0, 1, 1);
        step("drop idle", 0, 0, 8'h00, 32'h0, 0, 0);
        chk_val("drop mem30", wmem[8'h30], 32'h11);
        chk_val("drop mem31", wmem[8'h31], 32'h22);
        chk_val("drop mem32", wmem[8'h32], 32'h33);

        // Address wrap, ignored second start, reset mid-transfer
        issue(8'hFE, 8'h60, 8'd3);
        step("wrap req0", 1, 0, 8'h00, 32'h0, 1, 0);
        src_addr = 8'h80;
        dst_addr = 8'h90;
        length   = 8'd5;
        start    = 1'b1;
        step("wrap req1", 1, 0, 8'h00, 32'h0, 1, 0);
        step("wrap rd0",  1, 0, 8'hFE, 32'h0, 1, 0);
        step("wrap wr0",  1, 1, 8'h60, 32'hAA, 1, 0);
        step("wrap rd1",  1, 0, 8'hFF, 32'h0, 1, 0);
        step("wrap wr1",  1, 1, 8'h61, 32'hBB, 1, 0);
        step("wrap rd2",  1, 0, 8'h00, 32'h0, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk("rst async", 0, 0, 8'h00, 32'h0, 0, 0);
        @(negedge clk);
        chk("rst held", 0, 0, 8'h00, 32'h0, 0, 0);
        reset_n = 1'b1;
        step("rst idle", 0, 0, 8'h00, 32'h0, 0, 0);

        // One-word copy after reset starts cleanly from IDLE
        issue(8'h01, 8'h70, 8'd1);
        step("one req0", 1, 0, 8'h00, 32'h0, 1, 0);
        step("one req1", 1, 0, 8'h00, 32'h0, 1, 0);
        step("one rd0",  1, 0, 8'h01, 32'h0, 1, 0);
        step("one wr0",  1, 1, 8'h70, 32'hB, 1, 0);
        step("one done", 0, 0, 8'h00, 32'h0, 1, 1);
        step("one idle", 0, 0, 8'h00, 32'h0, 0, 0);
        chk_val("one mem70", wmem[8'h70], 32'hB);

        // 3 + 2 + 3 + 2 (before reset) + 1 writes; reset transfer gives no done
        chk_val("write count", wr_cnt, 32'd11);
        chk_val("done count", done_cnt, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
